// File: rtl/clock_pkg.sv
// clock_pkg
// Shared definitions for the clock time-setting controller:
//   - mode/state encodings (ST_*)
//   - key_vld bit indices (KEY_*)
//   - field maxima used by the compare-and-wrap arithmetic
//   - wrap_inc / wrap_dec helpers for one time field
package clock_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_SET_HOUR = 2'd1;
  localparam logic [1:0] ST_SET_MIN  = 2'd2;
  localparam logic [1:0] ST_SET_SEC  = 2'd3;

  localparam int KEY_MODE = 0;
  localparam int KEY_INC  = 1;
  localparam int KEY_DEC  = 2;

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] SEC_MAX  = 6'd59;

  // Fields never hold out-of-range values, so a compare against the maximum
  // is enough to wrap; no modulo operator is needed.
  function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] max);
    return (val >= max) ? 6'd0 : val + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] val, input logic [5:0] max);
    return (val == 6'd0) ? max : val - 6'd1;
  endfunction

endpackage

// File: rtl/clock_tick_gen.sv
// clock_tick_gen
// 1 Hz prescaler. Counts 0..TICK_DIV-1 and wraps; tick is high during the
// cycle the counter sits at TICK_DIV-1, so the owner acts on the wrap edge.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   hold       : clears the count to 0 on the next edge (held while setting)
//   tick       : high in the last cycle of each TICK_DIV-cycle period
module clock_tick_gen #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic tick
);

  localparam int              CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (hold || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Not gated by hold: a tick that lands in the same cycle as a MODE press
  // out of RUN still has to be applied.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
// Key-driven timekeeping and time-setting controller. Runs the mode FSM,
// owns the hour/minute/second registers and drives the 1 Hz prescaler.
// Optional feature macro: BLINK_EN (blink the field being edited).
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   key_vld[2:0]: one-cycle key pulses, bit0 MODE, bit1 INC, bit2 DEC
//   hour/minute/second : binary time
//   mode[1:0]   : current FSM state
//   blink_mask  : high = blank field (bit2 hour, bit1 minute, bit0 second)
//   sec_tick    : one-cycle pulse per RUN-mode second advance
//
// state        | meaning
// -------------+-----------------------------------------------
// ST_RUN       | time advances on each prescaler wrap
// ST_SET_HOUR  | time frozen, INC/DEC edit hour
// ST_SET_MIN   | time frozen, INC/DEC edit minute
// ST_SET_SEC   | time frozen, INC/DEC edit second
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_DIV = CLK_FREQ
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] key_vld,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [1:0] mode,
  output logic [2:0] blink_mask,
  output logic       sec_tick
);

  logic       k_mode, k_inc, k_dec;
  logic       tick, run_tick;
  logic [1:0] mode_d;
  logic [4:0] hour_d;
  logic [5:0] minute_d, second_d;

  // MODE > INC > DEC; lower-priority keys in the same cycle are dropped.
  assign k_mode = key_vld[KEY_MODE];
  assign k_inc  = key_vld[KEY_INC] & ~key_vld[KEY_MODE];
  assign k_dec  = key_vld[KEY_DEC] & ~key_vld[KEY_MODE] & ~key_vld[KEY_INC];

  // Hold is driven from the next state: the prescaler stays cleared while
  // setting, and on the SET_SEC->RUN edge it already advances to 1, so the
  // first tick lands exactly TICK_DIV cycles after the MODE pulse.
  clock_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (mode_d != ST_RUN),
    .tick  (tick)
  );

  always_comb begin
    mode_d   = mode;
    hour_d   = hour;
    minute_d = minute;
    second_d = second;
    run_tick = 1'b0;
    case (mode)
      ST_RUN: begin
        run_tick = tick;
        if (tick) begin
          second_d = wrap_inc(second, SEC_MAX);
          if (second == SEC_MAX) begin
            minute_d = wrap_inc(minute, MIN_MAX);
            if (minute == MIN_MAX) begin
              hour_d = 5'(wrap_inc({1'b0, hour}, HOUR_MAX));
            end
          end
        end
        if (k_mode) mode_d = ST_SET_HOUR;
      end
      ST_SET_HOUR: begin
        if (k_mode)      mode_d = ST_SET_MIN;
        else if (k_inc)  hour_d = 5'(wrap_inc({1'b0, hour}, HOUR_MAX));
        else if (k_dec)  hour_d = 5'(wrap_dec({1'b0, hour}, HOUR_MAX));
      end
      ST_SET_MIN: begin
        if (k_mode)      mode_d   = ST_SET_SEC;
        else if (k_inc)  minute_d = wrap_inc(minute, MIN_MAX);
        else if (k_dec)  minute_d = wrap_dec(minute, MIN_MAX);
      end
      ST_SET_SEC: begin
        if (k_mode)      mode_d   = ST_RUN;
        else if (k_inc)  second_d = wrap_inc(second, SEC_MAX);
        else if (k_dec)  second_d = wrap_dec(second, SEC_MAX);
      end
      default: mode_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= ST_RUN;
      hour     <= '0;
      minute   <= '0;
      second   <= '0;
      sec_tick <= 1'b0;
    end else begin
      mode     <= mode_d;
      hour     <= hour_d;
      minute   <= minute_d;
      second   <= second_d;
      sec_tick <= run_tick;
    end
  end

`ifdef BLINK_EN
  localparam int            HALF = TICK_DIV / 2;
  localparam int            BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BW-1:0] BLAST = BW'(HALF - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  logic          key_act;

  assign key_act = k_mode | k_inc | k_dec;

  // Restart with the field visible after any key action and whenever the
  // next state is RUN, so every entry into a SET state starts shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (key_act || (mode_d == ST_RUN)) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BLAST) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    blink_mask = 3'b000;
    if (blink_ph) begin
      case (mode)
        ST_SET_HOUR: blink_mask = 3'b100;
        ST_SET_MIN:  blink_mask = 3'b010;
        ST_SET_SEC:  blink_mask = 3'b001;
        default:     blink_mask = 3'b000;
      endcase
    end
  end
`else
  assign blink_mask = 3'b000;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl
// Self-checking bench for clock_set_ctrl with TICK_DIV = 10. A behavioural
// model (time kept as plain integers, ticks as a countdown of edges) is
// compared with every DUT output on each falling edge; directed scenarios
// add literal expectations, then randomized key traffic runs on top.
// Build with BLINK_EN defined to exercise the blink feature.
module tb_clock_set_ctrl;

  localparam int TD   = 10;
  localparam int HALF = TD / 2;

  localparam logic [2:0] K_MODE = 3'b001;
  localparam logic [2:0] K_INC  = 3'b010;
  localparam logic [2:0] K_DEC  = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key_vld = 3'b000;
  logic [4:0] hour;
  logic [5:0] minute, second;
  logic [1:0] mode;
  logic [2:0] blink_mask;
  logic       sec_tick;

  clock_set_ctrl #(
    .CLK_FREQ (TD * 10),
    .TICK_DIV (TD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_vld    (key_vld),
    .hour       (hour),
    .minute     (minute),
    .second     (second),
    .mode       (mode),
    .blink_mask (blink_mask),
    .sec_tick   (sec_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int dut_ticks = 0;

  // Model state: mode 0..3, fields as ints, edges left until next tick,
  // edges since the last blink restart.
  int m_mode = 0, m_h = 0, m_m = 0, m_s = 0, m_tick = 0;
  int left = TD;
  int age = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_mask();
`ifdef BLINK_EN
    if (m_mode == 0 || ((age / HALF) % 2) == 0) return 0;
    return 1 << (3 - m_mode);
`else
    return 0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int tot;
    int d;
    bit km, ki, kd;
    if (!rst_n) begin
      m_mode = 0; m_h = 0; m_m = 0; m_s = 0; m_tick = 0;
      left = TD; age = 0;
    end else begin
      km = key_vld[0];
      ki = key_vld[1] && !key_vld[0];
      kd = key_vld[2] && !key_vld[1] && !key_vld[0];
      if (m_mode == 0) begin
        left = left - 1;
        m_tick = 0;
        if (left == 0) begin
          tot = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
          m_h = tot / 3600;
          m_m = (tot / 60) % 60;
          m_s = tot % 60;
          m_tick = 1;
          left = TD;
        end
        if (km) begin
          m_mode = 1;
          age = 0;
        end
      end else begin
        m_tick = 0;
        age = age + 1;
        if (km) begin
          m_mode = (m_mode + 1) % 4;
          age = 0;
          // The MODE edge itself is the first of the TD edges to the tick.
          if (m_mode == 0) left = TD - 1;
        end else if (ki || kd) begin
          d = ki ? 1 : -1;
          case (m_mode)
            1:       m_h = (m_h + 24 + d) % 24;
            2:       m_m = (m_m + 60 + d) % 60;
            default: m_s = (m_s + 60 + d) % 60;
          endcase
          age = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("hour",       int'(hour),       m_h);
      chk("minute",     int'(minute),     m_m);
      chk("second",     int'(second),     m_s);
      chk("mode",       int'(mode),       m_mode);
      chk("sec_tick",   int'(sec_tick),   m_tick);
      chk("blink_mask", int'(blink_mask), exp_mask());
      if (sec_tick) dut_ticks++;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    key_vld = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dut_ticks = 0;
  endtask

  task automatic press(input logic [2:0] k);
    key_vld = k;
    @(posedge clk);
    #1;
    key_vld = 3'b000;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    int s_m, s_s, t0, r;
    logic [2:0] k;

    @(posedge clk);
    do_reset();
    chk("reset_mode", int'(mode), 0);
    chk("reset_time", int'(hour) + int'(minute) + int'(second), 0);
    chk("reset_blink", int'(blink_mask), 0);
    chk("reset_tick", int'(sec_tick), 0);

    // 600 cycles of RUN -> 60 ticks, 00:01:00
    step(600);
    chk("run600_hour", int'(hour), 0);
    chk("run600_min", int'(minute), 1);
    chk("run600_sec", int'(second), 0);
    @(negedge clk); #1;
    chk("run600_ticks", dut_ticks, 60);

    // Preload 23:59:59 then roll over
    press(K_MODE);
    for (int i = 0; i < 30 && m_h != 23; i++) press(K_DEC);
    press(K_MODE);
    for (int i = 0; i < 70 && m_m != 59; i++) press(K_DEC);
    press(K_MODE);
    for (int i = 0; i < 70 && m_s != 59; i++) press(K_DEC);
    chk("preload_hour", int'(hour), 23);
    chk("preload_min", int'(minute), 59);
    chk("preload_sec", int'(second), 59);
    chk("preload_mode", int'(mode), 3);
    press(K_MODE);
    step(8);
    chk("rollover_early_tick", int'(sec_tick), 0);
    step(1);
    chk("rollover_tick", int'(sec_tick), 1);
    chk("rollover_hour", int'(hour), 0);
    chk("rollover_min", int'(minute), 0);
    chk("rollover_sec", int'(second), 0);

    // Hour wraps 0 -> 23 on DEC, others untouched
    press(K_MODE);
    s_m = m_m; s_s = m_s;
    press(K_DEC);
    chk("hour_dec_wrap", int'(hour), 23);
    chk("hour_dec_min", int'(minute), s_m);
    chk("hour_dec_sec", int'(second), s_s);
    press(K_MODE);
    for (int i = 0; i < 70 && m_m != 59; i++) press(K_INC);
    press(K_INC);
    chk("min_inc_wrap", int'(minute), 0);
    chk("min_inc_hour", int'(hour), 23);

    // Key priority
    press(K_MODE);
    press(K_MODE);
    s_s = m_s;
    press(3'b111);
    chk("prio111_mode", int'(mode), 1);
    chk("prio111_hour", int'(hour), 23);
    chk("prio111_min", int'(minute), 0);
    chk("prio111_sec", int'(second), s_s);
    press(K_MODE);
    press(3'b110);
    chk("prio110_min", int'(minute), 1);
    chk("prio110_hour", int'(hour), 23);
    chk("prio110_mode", int'(mode), 2);

    // Frozen in SET_MIN, then tick restart timing
    s_s = m_s;
    @(negedge clk); #1;
    t0 = dut_ticks;
    step(50);
    @(negedge clk); #1;
    chk("setmin_no_ticks", dut_ticks - t0, 0);
    chk("setmin_sec_frozen", int'(second), s_s);
    press(K_MODE);
    press(K_MODE);
    step(8);
    chk("restart_early_tick", int'(sec_tick), 0);
    step(1);
    chk("restart_tick", int'(sec_tick), 1);

    // Blink in SET_HOUR
    press(K_MODE);
    for (int kk = 1; kk <= 18; kk++) begin
`ifdef BLINK_EN
      chk("blink_seq", int'(blink_mask), (((kk - 1) / HALF) % 2 == 1) ? 4 : 0);
`else
      chk("blink_seq", int'(blink_mask), 0);
`endif
      step(1);
    end
`ifdef BLINK_EN
    chk("blink_before_inc", int'(blink_mask), 4);
`else
    chk("blink_before_inc", int'(blink_mask), 0);
`endif
    press(K_INC);
    chk("blink_after_inc", int'(blink_mask), 0);

    // Randomized traffic with a mid-edit reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        for (int j = 0; j < 4 && m_mode != 2; j++) press(K_MODE);
        chk("midedit_mode_before", int'(mode), 2);
        do_reset();
        chk("midedit_reset_mode", int'(mode), 0);
        chk("midedit_reset_time", int'(hour) + int'(minute) + int'(second), 0);
      end
      r = int'($urandom_range(0, 31));
      k = (r < 2) ? 3'($urandom_range(1, 7)) : 3'b000;
      press(k);
    end

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
